// File: rtl/drfa_pkg.sv
// drfa_pkg: shared widths and stack entry type for the DRFA CPU control path
package drfa_pkg;
  localparam int PC_WIDTH = 9;
  localparam int FLAGS_WIDTH = 4;
  typedef struct packed {
    logic [FLAGS_WIDTH-1:0] flags;
    logic [PC_WIDTH-1:0]    pc;
  } stack_entry_t;
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: spill storage below the top-of-stack, sync write / async read
module stack_regfile
  import drfa_pkg::*;
#(
  parameter int N  = 7,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  stack_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output stack_entry_t  rdata
);
  stack_entry_t mem [N];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // addresses past the last spill slot occur when depth < 2; the top then loads zero anyway
  assign rdata = raddr < AW'(N) ? mem[raddr] : '0;
endmodule

// File: rtl/call_stack.sv
// call_stack: return stack with a show-ahead top register and sticky over/underflow flags
module call_stack
  import drfa_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_push_en,
  input  logic                   in_pop_en,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [FLAGS_WIDTH-1:0] in_flags,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [FLAGS_WIDTH-1:0] out_flags,
  output logic [$clog2(DEPTH):0] out_depth,
  output logic                   out_empty,
  output logic                   out_full,
  output logic                   out_overflow,
  output logic                   out_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  logic [DW-1:0] depth;
  stack_entry_t top, spill_rd, new_entry;
  logic empty, full, do_push, do_tail, do_pop;
  assign new_entry = '{flags: in_flags, pc: in_pc};
  assign empty = depth == '0;
  assign full = depth == DW'(DEPTH);
  // push+pop on an empty stack degrades to a plain push
  assign do_tail = in_push_en && in_pop_en && !empty;
  assign do_push = in_push_en && !full && !do_tail;
  assign do_pop = in_pop_en && !in_push_en && !empty;
  stack_regfile #(.N(DEPTH - 1), .AW(AW)) u_regfile (
    .clk   (clk),
    .we    (do_push && !empty),
    .waddr (AW'(depth - DW'(1))),
    .wdata (top),
    .raddr (AW'(depth - DW'(2))),
    .rdata (spill_rd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      top <= '0;
      out_overflow <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (do_push) begin
        top <= new_entry;
        depth <= depth + DW'(1);
      end else if (do_tail) begin
        top <= new_entry;
      end else if (do_pop) begin
        top <= depth >= DW'(2) ? spill_rd : '0;
        depth <= depth - DW'(1);
      end
      if (in_push_en && !in_pop_en && full) out_overflow <= 1'b1;
      if (in_pop_en && !in_push_en && empty) out_underflow <= 1'b1;
    end
  end
  assign out_pc = top.pc;
  assign out_flags = top.flags;
  assign out_depth = depth;
  assign out_empty = empty;
  assign out_full = full;
endmodule
